// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: accepts a 16-bit word over a valid/ready
// handshake and streams it LSB first over a second valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a new word; SR/CNT hold
// SHIFT | presenting SR[0]; shifts on each downstream transfer
module serial_word_tx (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] IN,
  input  logic        LOAD,
  output logic        READY,
  output logic        SOUT,
  output logic        SVALID,
  input  logic        SREADY,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sr_q    <= 16'h0000;
      cnt_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (LOAD) begin
          sr_d    = IN;
          cnt_d   = 5'd16;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (SREADY) begin
          sr_d  = {1'b0, sr_q[15:1]};
          cnt_d = cnt_q - 5'd1;
          // Last bit leaves on this transfer; DONE shows in the first IDLE cycle.
          if (cnt_q == 5'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign READY  = (state_q == IDLE);
  assign SVALID = (state_q == SHIFT);
  assign BUSY   = (state_q == SHIFT);
  assign SOUT   = sr_q[0];
  assign DONE   = done_q;

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- CLK  input  1  sole clock; all state updates on the rising edge.
- RST_N  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- IN  input  16  parallel word to transmit.
- LOAD  input  1  upstream valid; the word on IN is offered.
- READY  output  1  upstream ready; a word is accepted when LOAD && READY.
- SOUT  output  1  serial data bit, LSB first.
- SVALID  output  1  SOUT holds a valid bit.
- SREADY  input  1  downstream ready; a bit is transferred when SVALID && SREADY.
- BUSY  output  1  a word is being shifted out.
- DONE  output  1  one-cycle pulse after the last bit of a word is transferred.
REQ-003 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from any input to any output.

Function
REQ-004 The block SHALL contain a 16-bit shift register SR, a 5-bit count CNT and a 2-state FSM with states IDLE and SHIFT.
REQ-005 In IDLE, outputs SHALL be: READY=1, SVALID=0, BUSY=0.
REQ-006 In IDLE with LOAD=1, the block SHALL capture SR<=IN and CNT<=16, and SHALL enter SHIFT on the next edge.
REQ-007 In IDLE with LOAD=0, SR and CNT SHALL hold their values (hold semantics of the 16-bit storage register).
REQ-008 In SHIFT, outputs SHALL be: READY=0, SVALID=1, BUSY=1, SOUT=SR[0].
REQ-009 In SHIFT with SREADY=1, the block SHALL shift SR right by one with zero fill (SR<={1'b0,SR[15:1]}) and decrement CNT by 1.
REQ-010 In SHIFT with SREADY=0, SR, CNT and SOUT SHALL hold, and SVALID SHALL stay 1; a presented bit is never withdrawn.
REQ-011 In SHIFT, a transfer with CNT==1 (the 16th bit) SHALL cause a transition to IDLE, and DONE SHALL be 1 for exactly the following cycle.
REQ-012 DONE SHALL be 0 in all other cycles.
REQ-013 LOAD asserted during SHIFT SHALL be ignored: no capture occurs, and the in-flight word is unaffected.
REQ-014 Latency: the first bit SHALL appear on SOUT with SVALID=1 exactly one cycle after the accepting LOAD edge.
REQ-015 With SREADY held at 1, a word SHALL occupy exactly 16 SHIFT cycles.
REQ-016 READY SHALL return to 1 in the same cycle DONE=1, so back-to-back words cost one IDLE cycle, giving 17 cycles per word.
REQ-017 Bit order SHALL be IN[0] first through IN[15] last.
REQ-018 The value of IN SHALL be irrelevant except in the accepting cycle.

Reset
REQ-019 When RST_N=0 at a rising edge, the block SHALL enter IDLE and clear SR and CNT to 0.
REQ-020 On that reset, DONE=0, SVALID=0, BUSY=0, SOUT=0 and READY=1 SHALL hold from the next cycle.
REQ-021 A reset during SHIFT SHALL abort the word: no DONE pulse, and the remaining bits are discarded.
REQ-022 Reset SHALL take priority over LOAD and SREADY in the same cycle.
REQ-023 RST_N SHALL have no asynchronous effect: it acts only at a clock edge.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Reset, then idle: RST_N=0 for 2 cycles, then 1 -> READY=1, SVALID=0, BUSY=0, DONE=0, SOUT=0.
- Single word: IN=16'hA5C3, LOAD pulse, SREADY=1 -> SOUT sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles, then DONE=1 for 1 cycle, then READY=1.
- Backpressure: IN=16'h0001, SREADY=0 for 5 cycles after the first bit -> SOUT=1 and SVALID=1 held for 5 cycles, and the remaining 15 bits are 0 once SREADY=1.
- LOAD while busy: IN=16'hFFFF accepted, then IN=16'h0000 with LOAD=1 at cycle 4 -> all 16 bits are 1, and the second word is not sent.
- Back-to-back: words 16'h1234 and 16'h8001 with LOAD held high -> DONE pulses 17 cycles apart, and both bit streams are correct.
- Mid-word reset: RST_N=0 after 7 bits of 16'hFFFF -> next cycle IDLE, SVALID=0, no DONE, and a following word transmits cleanly.
